fir_cfg_seq: RTL and testbench
==============================

FIR_CFG_SEQ -- requirements
Module: fir_cfg_seq

Interface
REQ-001 Parameter MAX_TAPS, default 16: largest tap count the tile chain holds.
REQ-002 Parameter DATA_W, default 16: width of sample and coefficient.
REQ-003 Parameter MODE_W, default 2; SHIFT_W, default 5; NUM_W = $clog2(MAX_TAPS+1).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_valid/cfg_ready  in/out  1/1  configuration request handshake.
REQ-007 cfg_mode, cfg_shift, cfg_num  in  MODE_W/SHIFT_W/NUM_W  requested mode, output shift, tap count.
REQ-008 tap_valid/tap_ready  in/out  1/1  coefficient input handshake; tap_data  in  DATA_W.
REQ-009 cont_valid, cont_flush  out  1/1  control word strobe and flush flag to first tile.
REQ-010 cont_mode, cont_shift, cont_num  out  MODE_W/SHIFT_W/NUM_W  control word fields.
REQ-011 tap_load_valid  out  1; tap_load_data  out  DATA_W  coefficient stream into tile chain.
REQ-012 chain_ready  in  1  first tile output buffer empty.
REQ-013 smp_in_valid/smp_in_ready  in/out  1/1; smp_in_data  in  DATA_W  upstream samples.
REQ-014 smp_out_valid  out  1; smp_out_data  out  DATA_W  samples into tile chain.
REQ-015 busy  out  1; cfg_err  out  1  one-cycle pulse on rejected request.

Function
REQ-016 States SHALL be IDLE, FLUSH, DRAIN, CONFIG, LOAD, RUN; reset state IDLE.
REQ-017 cfg_ready SHALL be 1 only in IDLE and RUN; elsewhere requests wait.
REQ-018 Accepted request with cfg_num > MAX_TAPS SHALL pulse cfg_err next cycle, be discarded, and leave state unchanged.
REQ-019 Legal accepted request SHALL latch mode/shift/num and go to FLUSH next cycle.
REQ-020 FLUSH SHALL last exactly one cycle with cont_valid=1, cont_flush=1, other cont fields 0; then DRAIN.
REQ-021 DRAIN SHALL count 8 cycles, then stay until chain_ready=1, then go CONFIG.
REQ-022 CONFIG SHALL last one cycle: cont_valid=1, cont_flush=0, cont fields = latched values; next LOAD if num>0 else RUN.
REQ-023 In LOAD tap_ready SHALL be 1; each accepted tap SHALL appear on tap_load_valid/data exactly one cycle later, in arrival order.
REQ-024 LOAD SHALL exit to RUN in the cycle after the num-th tap is accepted; tap_ready=0 outside LOAD.
REQ-025 In RUN smp_in_ready SHALL equal chain_ready; smp_out_valid/data SHALL register accepted samples with 1-cycle latency; smp_out_valid=0 outside RUN.
REQ-026 Request accepted in RUN SHALL stop sample acceptance that same cycle; a sample accepted that cycle still emits.
REQ-027 cont_valid, tap_load_valid, smp_out_valid SHALL never be 1 simultaneously except smp_out_valid in the FLUSH cycle per REQ-026.
REQ-028 busy SHALL be 1 in FLUSH, DRAIN, CONFIG, LOAD.
REQ-029 cfg_valid with cfg_ready=0 SHALL not be consumed and SHALL produce no cfg_err.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, all counters 0, all outputs 0, latched config 0, regardless of state.
REQ-031 Reset mid-LOAD SHALL discard partial taps; no flush is issued on reset exit.

Structure
REQ-032 FIR control word struct, tap-load struct, state enum and MAX_TAPS default SHALL live in the shared FIR package.
REQ-033 Sub-module fir_cfg_seq_cnt (loadable up-counter with terminal flag) SHALL serve both drain and tap counts.

Verification
REQ-034 Reset, cfg num=4 mode=1 shift=3, chain_ready=1 -> flush pulse, 8 drain cycles, control word (1,3,4), 4 taps forwarded, RUN.
REQ-035 cfg num=0 -> FLUSH, DRAIN, CONFIG, then RUN with no tap_load_valid.
REQ-036 cfg num=17 (MAX_TAPS=16) -> cfg_err pulse, state IDLE, no cont_valid.
REQ-037 RUN, chain_ready toggled 1/0 per cycle with continuous samples -> smp_in_ready tracks chain_ready, no sample lost or duplicated.
REQ-038 rst asserted after 2 of 4 taps -> outputs 0 same cycle; new cfg completes with exactly 4 taps.
REQ-039 Reconfig during RUN with chain_ready held 0 for 20 cycles -> DRAIN holds 20 cycles, CONFIG follows chain_ready rising.

Source files
------------

// File: rtl/fir_cfg_seq_pkg.sv
// Shared types for the FIR configuration sequencer:
// state encoding, control-word and tap-load bundles.
package fir_cfg_seq_pkg;

  localparam int MAX_TAPS_DEF = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int MODE_W_DEF   = 2;
  localparam int SHIFT_W_DEF  = 5;
  localparam int NUM_W_DEF    = $clog2(MAX_TAPS_DEF + 1);
  localparam int DRAIN_CYC    = 8;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    DRAIN,
    CONFIG,
    LOAD,
    RUN
  } state_e;

  typedef struct packed {
    logic                   flush;
    logic [MODE_W_DEF-1:0]  mode;
    logic [SHIFT_W_DEF-1:0] shift;
    logic [NUM_W_DEF-1:0]   num;
  } cont_word_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
  } tap_load_t;

endpackage

// File: rtl/fir_cfg_seq_if.sv
// Handshake bundle between the sequencer, its
// requester, the coefficient source and the tile chain.
interface fir_cfg_seq_if #(
  parameter int MAX_TAPS = fir_cfg_seq_pkg::MAX_TAPS_DEF,
  parameter int DATA_W   = fir_cfg_seq_pkg::DATA_W_DEF,
  parameter int MODE_W   = fir_cfg_seq_pkg::MODE_W_DEF,
  parameter int SHIFT_W  = fir_cfg_seq_pkg::SHIFT_W_DEF,
  parameter int NUM_W    = $clog2(MAX_TAPS + 1)
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MODE_W-1:0]  cfg_mode;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [NUM_W-1:0]   cfg_num;
  logic               tap_valid;
  logic               tap_ready;
  logic [DATA_W-1:0]  tap_data;
  logic               cont_valid;
  logic               cont_flush;
  logic [MODE_W-1:0]  cont_mode;
  logic [SHIFT_W-1:0] cont_shift;
  logic [NUM_W-1:0]   cont_num;
  logic               tap_load_valid;
  logic [DATA_W-1:0]  tap_load_data;
  logic               chain_ready;
  logic               smp_in_valid;
  logic               smp_in_ready;
  logic [DATA_W-1:0]  smp_in_data;
  logic               smp_out_valid;
  logic [DATA_W-1:0]  smp_out_data;
  logic               busy;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_mode, cfg_shift, cfg_num,
    output tap_valid, tap_data, chain_ready,
    output smp_in_valid, smp_in_data,
    input  cfg_ready, tap_ready, smp_in_ready,
    input  cont_valid, cont_flush, cont_mode,
    input  cont_shift, cont_num,
    input  tap_load_valid, tap_load_data,
    input  smp_out_valid, smp_out_data,
    input  busy, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_shift, cfg_num,
    input  tap_valid, tap_data, chain_ready,
    input  smp_in_valid, smp_in_data,
    output cfg_ready, tap_ready, smp_in_ready,
    output cont_valid, cont_flush, cont_mode,
    output cont_shift, cont_num,
    output tap_load_valid, tap_load_data,
    output smp_out_valid, smp_out_data,
    output busy, cfg_err
  );

endinterface

// File: rtl/fir_cfg_seq_cnt.sv
// Loadable up-counter; done_o flags that the count
// has reached the limit captured at load time.
module fir_cfg_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] lim_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] lim_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      lim_q <= lim_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = (cnt_q == lim_q);

endmodule

// File: rtl/fir_cfg_seq.sv
// Configuration sequencer: flushes the tile chain, waits
// for it to drain, issues the control word and streams taps.
module fir_cfg_seq
  import fir_cfg_seq_pkg::*;
#(
  parameter int MAX_TAPS = MAX_TAPS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MODE_W   = MODE_W_DEF,
  parameter int SHIFT_W  = SHIFT_W_DEF,
  parameter int NUM_W    = $clog2(MAX_TAPS + 1)
) (
  input logic          clk,
  input logic          rst,
  fir_cfg_seq_if.slave bus
);

  localparam int CNT_W = (NUM_W > 4) ? NUM_W : 4;
  localparam logic [NUM_W-1:0] MAX_N = NUM_W'(MAX_TAPS);

  state_e             state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic               err_q, err_d;
  logic               tl_vld_q;
  logic [DATA_W-1:0]  tl_dat_q;
  logic               so_vld_q;
  logic [DATA_W-1:0]  so_dat_q;

  logic             cfg_rdy, cfg_acc, cfg_ok;
  logic             tap_acc, smp_rdy, smp_acc;
  logic             cnt_load, cnt_inc, cnt_done;
  logic [CNT_W-1:0] cnt_lim;

  assign cfg_rdy = (state_q == IDLE) || (state_q == RUN);
  assign cfg_acc = bus.cfg_valid && cfg_rdy;
  assign cfg_ok  = (bus.cfg_num <= MAX_N);
  assign tap_acc = bus.tap_valid && (state_q == LOAD);
  assign smp_rdy = (state_q == RUN) && bus.chain_ready;
  assign smp_acc = bus.smp_in_valid && smp_rdy;

  fir_cfg_seq_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load_i(cnt_load),
    .inc_i (cnt_inc),
    .lim_i (cnt_lim),
    .done_o(cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    num_d    = num_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_lim  = '0;
    unique case (state_q)
      IDLE, RUN: begin
        if (cfg_acc && cfg_ok) begin
          mode_d  = bus.cfg_mode;
          shift_d = bus.cfg_shift;
          num_d   = bus.cfg_num;
          state_d = FLUSH;
        end else if (cfg_acc) begin
          err_d = 1'b1;
        end
      end
      FLUSH: begin
        cnt_load = 1'b1;
        cnt_lim  = CNT_W'(DRAIN_CYC - 1);
        state_d  = DRAIN;
      end
      DRAIN: begin
        cnt_inc = !cnt_done;
        // Tap count is armed here so LOAD starts from zero.
        if (cnt_done && bus.chain_ready) begin
          cnt_load = 1'b1;
          cnt_lim  = CNT_W'(num_q) - CNT_W'(1);
          state_d  = CONFIG;
        end
      end
      CONFIG: begin
        state_d = (num_q != '0) ? LOAD : RUN;
      end
      LOAD: begin
        if (tap_acc) begin
          cnt_inc = 1'b1;
          if (cnt_done) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      shift_q  <= '0;
      num_q    <= '0;
      err_q    <= 1'b0;
      tl_vld_q <= 1'b0;
      tl_dat_q <= '0;
      so_vld_q <= 1'b0;
      so_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      num_q    <= num_d;
      err_q    <= err_d;
      tl_vld_q <= tap_acc;
      tl_dat_q <= tap_acc ? bus.tap_data : '0;
      so_vld_q <= smp_acc;
      so_dat_q <= smp_acc ? bus.smp_in_data : '0;
    end
  end

  assign bus.cfg_ready      = cfg_rdy && !rst;
  assign bus.tap_ready      = (state_q == LOAD);
  assign bus.smp_in_ready   = smp_rdy;
  assign bus.cont_valid     = (state_q == FLUSH) || (state_q == CONFIG);
  assign bus.cont_flush     = (state_q == FLUSH);
  assign bus.cont_mode      = (state_q == CONFIG) ? mode_q : '0;
  assign bus.cont_shift     = (state_q == CONFIG) ? shift_q : '0;
  assign bus.cont_num       = (state_q == CONFIG) ? num_q : '0;
  assign bus.tap_load_valid = tl_vld_q;
  assign bus.tap_load_data  = tl_dat_q;
  assign bus.smp_out_valid  = so_vld_q;
  assign bus.smp_out_data   = so_dat_q;
  assign bus.busy           = !cfg_rdy;
  assign bus.cfg_err        = err_q;

endmodule

// File: tb/tb_fir_cfg_seq.sv
// Directed bench for fir_cfg_seq: per-cycle vector table
// plus hand sequences for reset, error and drain-hold cases.
module tb_fir_cfg_seq;
  import fir_cfg_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  fir_cfg_seq_if #(
    .MAX_TAPS(16), .DATA_W(16), .MODE_W(2), .SHIFT_W(5)
  ) bus ();

  fir_cfg_seq #(
    .MAX_TAPS(16), .DATA_W(16), .MODE_W(2), .SHIFT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          rep;
    logic        cv;
    logic [1:0]  cm;
    logic [4:0]  cs;
    logic [4:0]  cn;
    logic        tv;
    logic [15:0] td;
    logic        cr;
    logic        sv;
    logic [15:0] sd;
    state_e      st;
    logic [1:0]  em;
    logic [4:0]  es;
    logic [4:0]  en;
    logic        etv;
    logic [15:0] etd;
    logic        esv;
    logic [15:0] esd;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t r(
    input int rep, input logic cv, input logic [1:0] cm,
    input logic [4:0] cs, input logic [4:0] cn,
    input logic tv, input logic [15:0] td, input logic cr,
    input logic sv, input logic [15:0] sd, input state_e st,
    input logic [1:0] em, input logic [4:0] es,
    input logic [4:0] en, input logic etv,
    input logic [15:0] etd, input logic esv,
    input logic [15:0] esd, input logic err);
    vec_t v;
    v.rep = rep; v.cv = cv; v.cm = cm; v.cs = cs; v.cn = cn;
    v.tv = tv; v.td = td; v.cr = cr; v.sv = sv; v.sd = sd;
    v.st = st; v.em = em; v.es = es; v.en = en;
    v.etv = etv; v.etd = etd; v.esv = esv; v.esd = esd;
    v.err = err;
    return v;
  endfunction

  function automatic logic [52:0] obs();
    return {bus.cfg_ready, bus.cont_valid, bus.cont_flush,
            bus.cont_mode, bus.cont_shift, bus.cont_num,
            bus.tap_ready, bus.tap_load_valid, bus.tap_load_data,
            bus.smp_in_ready, bus.smp_out_valid, bus.smp_out_data,
            bus.busy, bus.cfg_err};
  endfunction

  function automatic logic [52:0] exp_word(input vec_t v);
    cont_word_t cw;
    tap_load_t  tl;
    logic rdy, cvld, trdy, srdy;
    cw   = '0;
    rdy  = (v.st == IDLE) || (v.st == RUN);
    cvld = (v.st == FLUSH) || (v.st == CONFIG);
    if (v.st == FLUSH) cw.flush = 1'b1;
    if (v.st == CONFIG) begin
      cw.mode  = v.em;
      cw.shift = v.es;
      cw.num   = v.en;
    end
    trdy = (v.st == LOAD);
    srdy = (v.st == RUN) && v.cr;
    tl.valid = v.etv;
    tl.data  = v.etd;
    return {rdy, cvld, cw, trdy, tl, srdy,
            v.esv, v.esd, !rdy, v.err};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_valid    = 1'b0;
    bus.cfg_mode     = '0;
    bus.cfg_shift    = '0;
    bus.cfg_num      = '0;
    bus.tap_valid    = 1'b0;
    bus.tap_data     = '0;
    bus.chain_ready  = 1'b1;
    bus.smp_in_valid = 1'b0;
    bus.smp_in_data  = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.cfg_valid    = v.cv;
    bus.cfg_mode     = v.cm;
    bus.cfg_shift    = v.cs;
    bus.cfg_num      = v.cn;
    bus.tap_valid    = v.tv;
    bus.tap_data     = v.td;
    bus.chain_ready  = v.cr;
    bus.smp_in_valid = v.sv;
    bus.smp_in_data  = v.sd;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_outs_zero", obs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int nacc, ntl, nd, got;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();

    // flow with 4 taps, then samples
    tbl.push_back(r(2, 0,0,0,0,  0,0,1, 0,0,       IDLE,  0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 1,1,3,4,  0,0,1, 0,0,       IDLE,  0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       FLUSH, 0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(8, 0,0,0,0,  0,0,1, 0,0,       DRAIN, 0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       CONFIG,1,3,4, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  1,16'hA1A1,1, 0,0, LOAD, 0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  1,16'hB2B2,1, 0,0, LOAD, 0,0,0, 1,16'hA1A1,0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       LOAD,  0,0,0, 1,16'hB2B2,0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  1,16'hC3C3,1, 0,0, LOAD, 0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  1,16'hD4D4,1, 0,0, LOAD, 0,0,0, 1,16'hC3C3,0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  1,16'hEEEE,1, 0,0, RUN,  0,0,0, 1,16'hD4D4,0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 1,16'h1111, RUN,  0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 1,16'h2222, RUN,  0,0,0, 0,0,       1,16'h1111,0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       RUN,   0,0,0, 0,0,       1,16'h2222,0));
    // reconfig num=0 with sample in the same cycle
    tbl.push_back(r(1, 1,2,7,0,  0,0,1, 1,16'h3333, RUN,  0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 1,16'h4444, FLUSH,0,0,0, 0,0,       1,16'h3333,0));
    tbl.push_back(r(8, 1,1,1,17, 0,0,1, 0,0,       DRAIN, 0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       CONFIG,2,7,0, 0,0,       0,0,       0));
    tbl.push_back(r(2, 0,0,0,0,  0,0,1, 0,0,       RUN,   0,0,0, 0,0,       0,0,       0));
    // oversize request while running
    tbl.push_back(r(1, 1,3,31,17,0,0,1, 0,0,       RUN,   0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       RUN,   0,0,0, 0,0,       0,0,       1));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       RUN,   0,0,0, 0,0,       0,0,       0));
    // chain_ready toggling with a held sample stream
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 1,16'hA000, RUN,  0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,0, 1,16'hA001, RUN,  0,0,0, 0,0,       1,16'hA000,0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 1,16'hA001, RUN,  0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,0, 1,16'hA002, RUN,  0,0,0, 0,0,       1,16'hA001,0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 1,16'hA002, RUN,  0,0,0, 0,0,       0,0,       0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       RUN,   0,0,0, 0,0,       1,16'hA002,0));
    tbl.push_back(r(1, 0,0,0,0,  0,0,1, 0,0,       RUN,   0,0,0, 0,0,       0,0,       0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs_zero", obs(), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        drive(tbl[i]);
        @(negedge clk);
        chk($sformatf("row%0d.%0d", i, k), obs(), exp_word(tbl[i]));
        @(posedge clk); #1;
      end
    end

    // oversize request from IDLE, then the legal maximum
    do_reset();
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'd1;
    bus.cfg_shift = 5'd1;
    bus.cfg_num   = 5'd17;
    @(negedge clk);
    chk("idle_rdy", bus.cfg_ready, 1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", {bus.cfg_err, bus.cfg_ready, bus.busy, bus.cont_valid}, 4'b1100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_once", {bus.cfg_err, bus.cfg_ready, bus.busy, bus.cont_valid}, 4'b0100);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    bus.cfg_num   = 5'd16;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("max_ok", {bus.cont_valid, bus.cont_flush, bus.busy, bus.cfg_err}, 4'b1110);
    @(posedge clk); #1;

    // reset after two of four taps, then a clean reload
    do_reset();
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'd1;
    bus.cfg_shift = 5'd3;
    bus.cfg_num   = 5'd4;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      @(negedge clk);
      if (bus.tap_ready) got = 1;
      @(posedge clk); #1;
    end
    chk("load_reach", got, 1);
    bus.tap_valid = 1'b1;
    bus.tap_data  = 16'h5A01;
    @(posedge clk); #1;
    bus.tap_data  = 16'h5A02;
    @(posedge clk); #1;
    bus.tap_valid = 1'b0;
    chk("tap2_fwd", {bus.tap_load_valid, bus.tap_load_data}, {1'b1, 16'h5A02});
    rst = 1'b1;
    #1;
    chk("rst_midload", obs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nacc = 0;
    ntl  = 0;
    for (int c = 0; c < 25; c++) begin
      bus.cfg_valid = (c == 0);
      bus.tap_valid = 1'b1;
      bus.tap_data  = 16'h6B00 + 16'(nacc);
      @(negedge clk);
      if (bus.tap_load_valid) begin
        chk("reload_order", bus.tap_load_data, 16'h6B00 + 16'(ntl));
        ntl++;
      end
      if (bus.tap_ready) nacc++;
      @(posedge clk); #1;
    end
    chk("reload_count", ntl, 4);
    chk("reload_run", {bus.cfg_ready, bus.busy, bus.tap_ready}, 3'b100);

    // reconfig from RUN while the chain stays full
    bus.tap_valid   = 1'b0;
    bus.chain_ready = 1'b0;
    bus.cfg_valid   = 1'b1;
    bus.cfg_mode    = 2'd2;
    bus.cfg_shift   = 5'd9;
    bus.cfg_num     = 5'd2;
    @(negedge clk);
    chk("run_rdy_lo", {bus.cfg_ready, bus.smp_in_ready}, 2'b10);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("flush2", {bus.cont_valid, bus.cont_flush, bus.cont_mode, bus.cont_shift, bus.cont_num}, {2'b11, 12'h0});
    @(posedge clk); #1;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.busy && !bus.cont_valid && !bus.tap_ready) nd++;
      @(posedge clk); #1;
    end
    chk("drain_hold", nd, 20);
    bus.chain_ready = 1'b1;
    @(negedge clk);
    chk("drain_last", bus.cont_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cfg_after", {bus.cont_valid, bus.cont_flush, bus.cont_mode, bus.cont_shift, bus.cont_num}, {1'b1, 1'b0, 2'd2, 5'd9, 5'd2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
